// File: rtl/lowq_kmer_scheduler.sv
// Sweeps a k-mer window across one read's 2-bit quality string, feeding the
// shared low-Q counter one window per cycle, and summarises the returned
// scores (best window, window count, clean-window count).
module lowq_kmer_scheduler #(
    parameter int unsigned MAX_KMER_BIT_WIDTH = 6,
    parameter int unsigned MAX_KMER_WIDTH     = 1 << MAX_KMER_BIT_WIDTH,
    parameter int unsigned MAX_READ_BIT_WIDTH = 8,
    parameter int unsigned MAX_READ_LEN       = 1 << MAX_READ_BIT_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    output logic                            ready_o,
    input  logic                            abort_i,
    input  logic [MAX_READ_BIT_WIDTH:0]     read_length_i,
    input  logic [MAX_KMER_BIT_WIDTH-1:0]   kmer_length_i,
    input  logic [1:0]                      threshold_i,
    input  logic [2*MAX_READ_LEN-1:0]       quality_read_i,
    output logic                            cnt_valid_o,
    output logic                            cnt_done_o,
    output logic [MAX_KMER_BIT_WIDTH-1:0]   cnt_kmer_length_o,
    output logic [2*MAX_KMER_WIDTH-1:0]     cnt_quality_o,
    output logic [1:0]                      cnt_threshold_o,
    input  logic [MAX_KMER_BIT_WIDTH-1:0]   cnt_num_low_q_i,
    input  logic                            cnt_valid_score_i,
    output logic                            result_valid_o,
    output logic                            result_error_o,
    output logic [MAX_READ_BIT_WIDTH-1:0]   best_pos_o,
    output logic [MAX_KMER_BIT_WIDTH-1:0]   best_count_o,
    output logic [MAX_READ_BIT_WIDTH:0]     num_kmers_o,
    output logic [MAX_READ_BIT_WIDTH:0]     num_clean_o
);

    localparam int unsigned KW = MAX_KMER_BIT_WIDTH;
    localparam int unsigned RW = MAX_READ_BIT_WIDTH;
    localparam int unsigned NW = MAX_READ_BIT_WIDTH + 1;
    localparam int unsigned QW = 2 * MAX_READ_LEN;
    localparam int unsigned CW = 2 * MAX_KMER_WIDTH;
    localparam logic [NW-1:0] NOne = NW'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StReport} state_e;

    state_e          state_q;
    logic            ready_q, cnt_valid_q, cnt_done_q, result_valid_q, result_error_q;
    logic [KW-1:0]   kmer_q, best_count_q;
    logic [1:0]      thr_q;
    logic [QW-1:0]   qual_q, qual_d;
    logic [NW-1:0]   n_q, n_d, issue_ctr_q, recv_ctr_q, num_kmers_q, num_clean_q;
    logic [RW-1:0]   best_pos_q;
    logic [NW-1:0]   k_zext;
    logic            accept, kmer_bad, score_hit, recv_done, last_issue;

    // Decode accept, window count and the score-side bookkeeping conditions.
    always_comb begin
        k_zext     = {{(NW-KW){1'b0}}, kmer_length_i};
        accept     = start_i & (state_q == StIdle) & ~abort_i;
        kmer_bad   = (kmer_length_i == '0) | (k_zext > read_length_i);
        n_d        = read_length_i - k_zext + NOne;
        last_issue = (issue_ctr_q == n_q - NOne);
        score_hit  = cnt_valid_score_i & ((state_q == StIssue) | (state_q == StDrain));
        // Exit on the cycle the final score is absorbed, not one later.
        recv_done  = (recv_ctr_q == n_q) | (score_hit & ((recv_ctr_q + NOne) == n_q));
    end

    // Zero bases past the read end so the shifted window never carries stale data.
    always_comb begin
        qual_d = '0;
        for (int i = 0; i < int'(MAX_READ_LEN); i++) begin
            if (i < int'(read_length_i)) qual_d[2*i +: 2] = quality_read_i[2*i +: 2];
        end
    end

    // Sequencer FSM with registered outputs and score accumulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            ready_q        <= 1'b1;
            cnt_valid_q    <= 1'b0;
            cnt_done_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_error_q <= 1'b0;
            kmer_q         <= '0;
            thr_q          <= '0;
            qual_q         <= '0;
            n_q            <= '0;
            issue_ctr_q    <= '0;
            recv_ctr_q     <= '0;
            best_count_q   <= '0;
            best_pos_q     <= '0;
            num_kmers_q    <= '0;
            num_clean_q    <= '0;
        end else if (abort_i && state_q != StIdle) begin
            // Cleanup cycle: release the counter without publishing a result.
            state_q        <= StReport;
            ready_q        <= 1'b0;
            cnt_valid_q    <= 1'b0;
            cnt_done_q     <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ready_q        <= 1'b0;
                        kmer_q         <= kmer_length_i;
                        thr_q          <= threshold_i;
                        qual_q         <= qual_d;
                        n_q            <= n_d;
                        issue_ctr_q    <= '0;
                        recv_ctr_q     <= '0;
                        best_pos_q     <= '0;
                        num_kmers_q    <= '0;
                        num_clean_q    <= '0;
                        result_error_q <= kmer_bad;
                        if (kmer_bad) begin
                            best_count_q   <= '0;
                            state_q        <= StReport;
                            result_valid_q <= 1'b1;
                            cnt_done_q     <= 1'b1;
                        end else begin
                            best_count_q   <= '1;
                            state_q        <= StIssue;
                            cnt_valid_q    <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    qual_q      <= qual_q >> 2;
                    issue_ctr_q <= issue_ctr_q + NOne;
                    if (last_issue) begin
                        cnt_valid_q <= 1'b0;
                        state_q     <= StDrain;
                    end
                end
                StDrain: begin
                    if (recv_done) begin
                        state_q        <= StReport;
                        result_valid_q <= 1'b1;
                        cnt_done_q     <= 1'b1;
                        num_kmers_q    <= n_q;
                    end
                end
                StReport: begin
                    result_valid_q <= 1'b0;
                    cnt_done_q     <= 1'b0;
                    ready_q        <= 1'b1;
                    state_q        <= StIdle;
                end
            endcase

            if (score_hit) begin
                recv_ctr_q <= recv_ctr_q + NOne;
                // Strict compare keeps the earliest position on ties.
                if (cnt_num_low_q_i < best_count_q) begin
                    best_count_q <= cnt_num_low_q_i;
                    best_pos_q   <= recv_ctr_q[RW-1:0];
                end
                if (cnt_num_low_q_i == '0) num_clean_q <= num_clean_q + NOne;
            end
        end
    end

    assign ready_o           = ready_q;
    assign cnt_valid_o       = cnt_valid_q;
    assign cnt_done_o        = cnt_done_q;
    assign cnt_kmer_length_o = kmer_q;
    assign cnt_quality_o     = qual_q[CW-1:0];
    assign cnt_threshold_o   = thr_q;
    assign result_valid_o    = result_valid_q;
    assign result_error_o    = result_error_q;
    assign best_pos_o        = best_pos_q;
    assign best_count_o      = best_count_q;
    assign num_kmers_o       = num_kmers_q;
    assign num_clean_o       = num_clean_q;

endmodule
